ard_frame_collector: RTL
========================

ARD_FRAME_COLLECTOR -- requirements
Module: ard_frame_collector

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 9, number of payload bytes per frame (>=1).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle clocks between bytes inside a frame (>=2).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port byte_in, input, 8, received UART byte; valid only when byte_valid=1.
REQ-007 SHALL have port byte_valid, input, 1, one-cycle strobe per received byte.
REQ-008 SHALL have port frame_data, output, 8*FRAME_BYTES, last accepted payload; first payload byte in bits [8*FRAME_BYTES-1 -: 8].
REQ-009 SHALL have port frame_valid, output, 1, one-cycle pulse when frame_data updates.
REQ-010 SHALL have port checksum_error, output, 1, one-cycle pulse on checksum mismatch.
REQ-011 SHALL have port timeout, output, 1, one-cycle pulse on inter-byte timeout abort.
REQ-012 SHALL have port error_count, output, 8, saturating count of checksum errors plus timeouts.

Function
REQ-013 SHALL implement states IDLE, COLLECT, CHECK.
REQ-014 IDLE: byte_valid with byte_in==SYNC_BYTE SHALL go to COLLECT with payload index 0 and running XOR 0; other bytes SHALL be ignored.
REQ-015 COLLECT: each byte_valid SHALL store byte_in at current index in a shadow buffer, XOR it into running checksum, increment index; after byte FRAME_BYTES-1 SHALL go to CHECK.
REQ-016 Bytes equal to SYNC_BYTE in COLLECT or CHECK SHALL be treated as ordinary data (no resync).
REQ-017 CHECK: on byte_valid, if byte_in equals running XOR, frame_data SHALL load the shadow buffer and frame_valid SHALL pulse on the next clock edge; state SHALL return to IDLE.
REQ-018 CHECK: on byte_valid with mismatch, frame_data SHALL hold, checksum_error SHALL pulse on next edge, state SHALL return to IDLE.
REQ-019 Inter-byte timer SHALL clear on every byte_valid and on entry to IDLE, and count only in COLLECT/CHECK.
REQ-020 When timer reaches TIMEOUT_CYCLES-1 with no byte_valid, state SHALL go to IDLE, timeout SHALL pulse, frame_data SHALL hold.
REQ-021 byte_valid in the same cycle as timer expiry SHALL take priority; no timeout.
REQ-022 error_count SHALL increment by 1 per checksum_error or timeout pulse and saturate at 255.
REQ-023 frame_valid, checksum_error and timeout SHALL be mutually exclusive and never high two consecutive cycles from one frame.
REQ-024 Shadow buffer writes SHALL not disturb frame_data until acceptance.
REQ-025 Timer width SHALL be $clog2(TIMEOUT_CYCLES); index width $clog2(FRAME_BYTES+1).

Reset
REQ-026 reset=1 SHALL force state IDLE, frame_data=0, frame_valid=0, checksum_error=0, timeout=0, error_count=0, timer=0, index=0.
REQ-027 reset mid-frame SHALL discard partial frame; byte_valid during reset SHALL be ignored.

Verification
REQ-028 FRAME_BYTES=2: bytes A5,12,34,26 -> frame_valid 1 cycle after byte 26, frame_data=16'h1234, error_count=0.
REQ-029 FRAME_BYTES=2: A5,12,34,00 -> checksum_error pulse, frame_data unchanged, error_count=1; then A5,AB,CD,66 -> frame_data=16'hABCD.
REQ-030 Noise 00,FF,5A then A5,A5,00,A5 -> noise ignored, frame_data=16'hA500, frame_valid once.
REQ-031 TIMEOUT_CYCLES=50: A5,12 then 50 idle cycles -> timeout pulse, state IDLE, error_count=1; byte at cycle 49 instead -> no timeout.
REQ-032 reset asserted after A5,12 -> all outputs 0; following A5,12,34,26 -> accepted normally.
REQ-033 300 consecutive bad-checksum frames -> error_count=255, holds.

Source files
------------

// File: rtl/ard_frame_collector_if.sv
// Byte-stream in / frame-out bundle shared by the frame collector and its producer.
// The producer drives the byte strobe; the collector returns frames, error pulses and the error tally.
interface ard_frame_collector_if #(
   parameter int FRAME_BYTES = 9
);
   logic [7:0]               byte_in;
   logic                     byte_valid;
   logic [8*FRAME_BYTES-1:0] frame_data;
   logic                     frame_valid;
   logic                     checksum_error;
   logic                     timeout;
   logic [7:0]               error_count;

   modport master (
      output byte_in, byte_valid,
      input  frame_data, frame_valid, checksum_error, timeout, error_count
   );

   modport slave (
      input  byte_in, byte_valid,
      output frame_data, frame_valid, checksum_error, timeout, error_count
   );
endinterface

// File: rtl/ard_frame_collector.sv
// Assembles sync-prefixed, XOR-checksummed byte frames from a UART byte stream.
// It publishes accepted payloads and counts checksum failures and inter-byte timeouts.
module ard_frame_collector #(
   parameter int         FRAME_BYTES    = 9,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk,
   input  logic                 reset,
   ard_frame_collector_if.slave bus
);
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
   localparam int INDEX_W = $clog2(FRAME_BYTES + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

   state_t                   stateReg;
   logic [INDEX_W-1:0]       indexReg;
   logic [7:0]               xorReg;
   logic [TIMER_W-1:0]       timerReg;
   logic [8*FRAME_BYTES-1:0] frameDataReg;
   logic                     frameValidReg;
   logic                     checksumErrorReg;
   logic                     timeoutReg;
   logic [7:0]               errorCountReg;
   logic [8*FRAME_BYTES-1:0] shadowFlat;

   // Shadow bytes are kept apart from frameDataReg so a frame in progress never shows on the output.
   genvar gi;
   generate
      for (gi = 0; gi < FRAME_BYTES; gi++) begin : g_shadow
         logic [7:0] shadowByte;
         always_ff @(posedge clk) begin
            if (!reset && stateReg == COLLECT && bus.byte_valid && indexReg == INDEX_W'(gi))
               shadowByte <= bus.byte_in;
         end
         assign shadowFlat[8*(FRAME_BYTES-gi)-1 -: 8] = shadowByte;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg         <= IDLE;
         indexReg         <= '0;
         xorReg           <= '0;
         timerReg         <= '0;
         frameDataReg     <= '0;
         frameValidReg    <= 1'b0;
         checksumErrorReg <= 1'b0;
         timeoutReg       <= 1'b0;
         errorCountReg    <= '0;
      end else begin
         frameValidReg    <= 1'b0;
         checksumErrorReg <= 1'b0;
         timeoutReg       <= 1'b0;
         case (stateReg)
            IDLE: begin
               timerReg <= '0;
               if (bus.byte_valid && bus.byte_in == SYNC_BYTE) begin
                  stateReg <= COLLECT;
                  indexReg <= '0;
                  xorReg   <= '0;
               end
            end
            COLLECT, CHECK: begin
               // An arriving byte wins over a timer expiring in the same cycle.
               if (bus.byte_valid) begin
                  timerReg <= '0;
                  if (stateReg == COLLECT) begin
                     xorReg   <= xorReg ^ bus.byte_in;
                     indexReg <= indexReg + 1'b1;
                     if (indexReg == INDEX_W'(FRAME_BYTES - 1))
                        stateReg <= CHECK;
                  end else begin
                     stateReg <= IDLE;
                     if (bus.byte_in == xorReg) begin
                        frameDataReg  <= shadowFlat;
                        frameValidReg <= 1'b1;
                     end else begin
                        checksumErrorReg <= 1'b1;
                        if (errorCountReg != 8'hFF)
                           errorCountReg <= errorCountReg + 8'd1;
                     end
                  end
               end else if (timerReg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                  stateReg   <= IDLE;
                  timerReg   <= '0;
                  timeoutReg <= 1'b1;
                  if (errorCountReg != 8'hFF)
                     errorCountReg <= errorCountReg + 8'd1;
               end else begin
                  timerReg <= timerReg + 1'b1;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign bus.frame_data     = frameDataReg;
   assign bus.frame_valid    = frameValidReg;
   assign bus.checksum_error = checksumErrorReg;
   assign bus.timeout        = timeoutReg;
   assign bus.error_count    = errorCountReg;
endmodule
